// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the two-client line-memory arbiter: default widths,
// FSM state encoding and transaction-owner encoding.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W     = 28;
  localparam int DEF_DATA_W     = 128;
  localparam int DEF_LINE_BEATS = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. On a tie the requester that did not win the
// previous accepted grant wins; last-grant resets to icache so dcache wins first.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_ic,
  input  logic req_dc,
  input  logic update,
  output logic grant_ic,
  output logic grant_dc
);

  owner_t last_q;
  logic   prefer_dc;

  assign prefer_dc = (last_q == OWNER_IC);
  assign grant_dc  = req_dc & (~req_ic | prefer_dc);
  assign grant_ic  = req_ic & (~req_dc | ~prefer_dc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= OWNER_IC;
    end else if (update) begin
      last_q <= grant_dc ? OWNER_DC : OWNER_IC;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache line reads and dcache line reads/writes onto a single
// memory port: one command, then LINE_BEATS data beats, per transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LINE_BEATS = DEF_LINE_BEATS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req_valid,
  output logic              ic_req_ready,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_resp_valid,
  output logic [DATA_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  output logic              dc_req_ready,
  input  logic              dc_req_rw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic              dc_wdata_valid,
  output logic              dc_wdata_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_resp_valid,
  output logic [DATA_W-1:0] dc_resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(LINE_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_BEATS - 1);

  state_t            state;
  owner_t            owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [CNT_W-1:0]  beat_cnt;

  logic grant_ic, grant_dc;
  logic in_idle, accept;
  logic rd_beat, wr_beat, beat, last_beat;

  assign in_idle = (state == IDLE);
  assign accept  = in_idle & (ic_req_valid | dc_req_valid);

  rr_arbiter2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req_ic   (ic_req_valid),
    .req_dc   (dc_req_valid),
    .update   (accept),
    .grant_ic (grant_ic),
    .grant_dc (grant_dc)
  );

  assign ic_req_ready = in_idle & grant_ic;
  assign dc_req_ready = in_idle & grant_dc;

  assign mem_req_valid = (state == ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_rw    = rw_q;

  // Read beats are only counted or forwarded while a read owns the port.
  assign rd_beat       = (state == RD_DATA) & mem_resp_valid;
  assign ic_resp_valid = rd_beat & (owner_q == OWNER_IC);
  assign dc_resp_valid = rd_beat & (owner_q == OWNER_DC);
  assign ic_resp_data  = mem_resp_data;
  assign dc_resp_data  = mem_resp_data;

  assign mem_wdata_valid = (state == WR_DATA) & dc_wdata_valid;
  assign dc_wdata_ready  = (state == WR_DATA) & mem_wdata_ready;
  assign mem_wdata       = dc_wdata;
  assign wr_beat         = mem_wdata_valid & mem_wdata_ready;

  assign beat      = rd_beat | wr_beat;
  assign last_beat = beat & (beat_cnt == LAST_BEAT);
  assign busy      = ~in_idle;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner_q  <= OWNER_IC;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            owner_q <= grant_dc ? OWNER_DC : OWNER_IC;
            addr_q  <= grant_dc ? dc_req_addr : ic_req_addr;
            rw_q    <= grant_dc & dc_req_rw;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_req_ready) begin
            state <= rw_q ? WR_DATA : RD_DATA;
          end
        end
        RD_DATA, WR_DATA: begin
          if (last_beat) begin
            beat_cnt <= '0;
            state    <= IDLE;
          end else if (beat) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with default parameters.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         ic_req_valid, ic_req_ready;
  logic [27:0]  ic_req_addr;
  logic         ic_resp_valid;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid, dc_req_ready, dc_req_rw;
  logic [27:0]  dc_req_addr;
  logic         dc_wdata_valid, dc_wdata_ready;
  logic [127:0] dc_wdata;
  logic         dc_resp_valid;
  logic [127:0] dc_resp_data;
  logic         mem_req_valid, mem_req_ready, mem_req_rw;
  logic [27:0]  mem_req_addr;
  logic         mem_wdata_valid, mem_wdata_ready;
  logic [127:0] mem_wdata;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  logic [127:0] beat_val [4];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_rw(dc_req_rw),
    .dc_req_addr(dc_req_addr), .dc_wdata_valid(dc_wdata_valid), .dc_wdata_ready(dc_wdata_ready),
    .dc_wdata(dc_wdata), .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_wdata_valid(mem_wdata_valid),
    .mem_wdata_ready(mem_wdata_ready), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    ic_req_valid = 0; ic_req_addr = '0;
    dc_req_valid = 0; dc_req_rw = 0; dc_req_addr = '0;
    dc_wdata_valid = 0; dc_wdata = '0;
    mem_req_ready = 0; mem_wdata_ready = 0;
    mem_resp_valid = 0; mem_resp_data = '0;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #1;
    reset = 1;
    clear_inputs();
    tick();
    reset = 0;
  endtask

  // From ISSUE: accept the command, then stream n read beats.
  task automatic finish_read(input int n);
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1;
    repeat (n) tick();
    mem_resp_valid = 0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    reset = 1;
    clear_inputs();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (mem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_req_valid got=%0b exp=0", mem_req_valid); end
    checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got=%b exp=00", {ic_resp_valid, dc_resp_valid}); end
    checks++; if ({dc_wdata_ready, mem_wdata_valid} !== 2'b00) begin errors++; $display("FAIL reset_wdata got=%b exp=00", {dc_wdata_ready, mem_wdata_valid}); end
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", {ic_req_ready, dc_req_ready}); end
    checks++; if (mem_req_addr !== 28'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_req_addr); end
    tick();
    reset = 0;
  endtask

  task automatic test_ic_read;
    int b;
    do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h0000123;
    #1;
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin errors++; $display("FAIL icrd_ready got=%b exp=10", {ic_req_ready, dc_req_ready}); end
    tick();
    ic_req_valid = 0;
    #1;
    checks++; if ({mem_req_valid, mem_req_rw, busy} !== 3'b101) begin errors++; $display("FAIL icrd_issue got=%b exp=101", {mem_req_valid, mem_req_rw, busy}); end
    checks++; if (mem_req_addr !== 28'h0000123) begin errors++; $display("FAIL icrd_addr got=%h exp=0000123", mem_req_addr); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    b = 0;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        mem_resp_valid = 0;
        #1;
        checks++; if (ic_resp_valid !== 1'b0) begin errors++; $display("FAIL icrd_stall got=%0b exp=0", ic_resp_valid); end
      end else begin
        mem_resp_valid = 1; mem_resp_data = beat_val[b];
        #1;
        checks++; if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b101) begin errors++; $display("FAIL icrd_beat%0d_valid got=%b exp=101", b, {ic_resp_valid, dc_resp_valid, busy}); end
        checks++; if (ic_resp_data !== beat_val[b]) begin errors++; $display("FAIL icrd_beat%0d_data got=%h exp=%h", b, ic_resp_data, beat_val[b]); end
        b++;
      end
      tick();
    end
    mem_resp_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL icrd_done_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_round_robin;
    do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h0000200;
    dc_req_valid = 1; dc_req_addr = 28'h0000300; dc_req_rw = 0;
    #1;
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin errors++; $display("FAIL rr_first got=%b exp=01", {ic_req_ready, dc_req_ready}); end
    tick();
    dc_req_valid = 0;
    #1;
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b00) begin errors++; $display("FAIL rr_busy_ready got=%b exp=00", {ic_req_ready, dc_req_ready}); end
    checks++; if (mem_req_addr !== 28'h0000300) begin errors++; $display("FAIL rr_dc_addr got=%h exp=0000300", mem_req_addr); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    mem_resp_valid = 1; mem_resp_data = beat_val[0];
    #1;
    checks++; if ({ic_resp_valid, dc_resp_valid} !== 2'b01) begin errors++; $display("FAIL rr_dc_resp got=%b exp=01", {ic_resp_valid, dc_resp_valid}); end
    repeat (4) tick();
    mem_resp_valid = 0;
    dc_req_valid = 1;
    #1;
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b10) begin errors++; $display("FAIL rr_second got=%b exp=10", {ic_req_ready, dc_req_ready}); end
    tick();
    ic_req_valid = 0;
    #1;
    checks++; if (mem_req_addr !== 28'h0000200) begin errors++; $display("FAIL rr_ic_addr got=%h exp=0000200", mem_req_addr); end
    finish_read(4);
    ic_req_valid = 1;
    #1;
    checks++; if ({ic_req_ready, dc_req_ready} !== 2'b01) begin errors++; $display("FAIL rr_third got=%b exp=01", {ic_req_ready, dc_req_ready}); end
    clear_inputs();
  endtask

  task automatic test_write;
    int beats;
    do_reset();
    dc_req_valid = 1; dc_req_rw = 1; dc_req_addr = 28'h0000040;
    tick();
    dc_req_valid = 0;
    #1;
    checks++; if ({mem_req_valid, mem_req_rw} !== 2'b11) begin errors++; $display("FAIL wr_issue got=%b exp=11", {mem_req_valid, mem_req_rw}); end
    checks++; if (mem_req_addr !== 28'h0000040) begin errors++; $display("FAIL wr_addr got=%h exp=0000040", mem_req_addr); end
    checks++; if (mem_wdata_valid !== 1'b0) begin errors++; $display("FAIL wr_wvalid_issue got=%0b exp=0", mem_wdata_valid); end
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    beats = 0;
    for (int c = 0; c < 16 && beats < 4; c++) begin
      dc_wdata_valid = 1; dc_wdata = beat_val[beats];
      mem_wdata_ready = (c % 2 == 0);
      #1;
      checks++; if (mem_wdata_valid !== 1'b1 || mem_wdata !== beat_val[beats]) begin errors++; $display("FAIL wr_beat%0d got=%0b/%h exp=1/%h", beats, mem_wdata_valid, mem_wdata, beat_val[beats]); end
      checks++; if (dc_wdata_ready !== mem_wdata_ready) begin errors++; $display("FAIL wr_ready_c%0d got=%0b exp=%0b", c, dc_wdata_ready, mem_wdata_ready); end
      if (mem_wdata_ready) beats++;
      tick();
    end
    dc_wdata_valid = 0; mem_wdata_ready = 1;
    #1;
    checks++; if (beats !== 4) begin errors++; $display("FAIL wr_beat_count got=%0d exp=4", beats); end
    checks++; if ({busy, dc_wdata_ready} !== 2'b00) begin errors++; $display("FAIL wr_done got=%b exp=00", {busy, dc_wdata_ready}); end
    mem_wdata_ready = 0;
  endtask

  task automatic test_stall;
    do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h0000066;
    dc_req_valid = 1; dc_req_addr = 28'h0000055; dc_req_rw = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 28'h0000055) begin errors++; $display("FAIL stall_c%0d got=%0b/%h exp=1/0000055", i, mem_req_valid, mem_req_addr); end
      checks++; if ({ic_req_ready, dc_req_ready} !== 2'b00) begin errors++; $display("FAIL stall_ready_c%0d got=%b exp=00", i, {ic_req_ready, dc_req_ready}); end
      tick();
    end
    ic_req_valid = 0; dc_req_valid = 0;
    finish_read(4);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_done got=%0b exp=0", busy); end
  endtask

  task automatic test_reset_midread;
    do_reset();
    ic_req_valid = 1; ic_req_addr = 28'h0000077;
    tick();
    ic_req_valid = 0;
    finish_read(2);
    mem_resp_valid = 1;
    reset = 1;
    #1;
    checks++; if ({busy, ic_resp_valid, mem_req_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_clear got=%b exp=000", {busy, ic_resp_valid, mem_req_valid}); end
    tick();
    reset = 0; mem_resp_valid = 0;
    ic_req_valid = 1; ic_req_addr = 28'h0000099;
    #1;
    checks++; if (ic_req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got=%0b exp=1", ic_req_ready); end
    tick();
    ic_req_valid = 0;
    mem_req_ready = 1;
    #1;
    checks++; if (mem_req_addr !== 28'h0000099) begin errors++; $display("FAIL rstmid_addr got=%h exp=0000099", mem_req_addr); end
    tick();
    mem_req_ready = 0; mem_resp_valid = 1;
    repeat (3) tick();
    #1;
    checks++; if ({busy, ic_resp_valid} !== 2'b11) begin errors++; $display("FAIL rstmid_beat3 got=%b exp=11", {busy, ic_resp_valid}); end
    tick();
    mem_resp_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%0b exp=0", busy); end
  endtask

  task automatic test_idle_resp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1; mem_resp_data = beat_val[i];
      #1;
      checks++; if ({ic_resp_valid, dc_resp_valid, busy} !== 3'b000) begin errors++; $display("FAIL idle_resp_c%0d got=%b exp=000", i, {ic_resp_valid, dc_resp_valid, busy}); end
      tick();
    end
    mem_resp_valid = 0;
    ic_req_valid = 1; ic_req_addr = 28'h00000AB;
    tick();
    ic_req_valid = 0;
    mem_req_ready = 1;
    tick();
    mem_req_ready = 0; mem_resp_valid = 1;
    repeat (3) tick();
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL idle_cnt_beat3 got=%0b exp=1", busy); end
    tick();
    mem_resp_valid = 0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_cnt_done got=%0b exp=0", busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    beat_val[0] = 128'hAAAA_0000_0000_0000_0000_0000_0000_000A;
    beat_val[1] = 128'hBBBB_0000_0000_0000_0000_0000_0000_000B;
    beat_val[2] = 128'hCCCC_0000_0000_0000_0000_0000_0000_000C;
    beat_val[3] = 128'hDDDD_0000_0000_0000_0000_0000_0000_000D;
    reset = 1;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_round_robin();
    test_write();
    test_stall();
    test_reset_midread();
    test_idle_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
